// File: rtl/ball_pkg.sv
// ball_pkg: shared types and constants for the fixed-point ball mover.
// Holds the play-state enum, default fixed-point widths and the serve LFSR.
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    SCORED     = 2'd3
  } ballState_t;

  localparam int X_WIDTH_DEF   = 8;
  localparam int Y_WIDTH_DEF   = 9;
  localparam int FRAC_BITS_DEF = 4;
  localparam int VEL_WIDTH_DEF = 6;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of a right-shifting Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1).
  function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
    lfsrStep = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// ball_axis_step: one axis of ball motion in unsigned fixed point.
// Moves pos by vel in the direction given (1 = increasing), clamps the result
// into [LIM_MIN, LIM_MAX] pixels and flags which limit the raw result reached.
module ball_axis_step #(
  parameter int INT_W   = 8,
  parameter int FRAC_W  = 4,
  parameter int VEL_W   = 6,
  parameter int LIM_MIN = 20,
  parameter int LIM_MAX = 220
) (
  input  logic [INT_W+FRAC_W-1:0] pos,
  input  logic [VEL_W-1:0]        vel,
  input  logic                    dir,
  output logic [INT_W+FRAC_W-1:0] nextPos,
  output logic                    atMin,
  output logic                    atMax
);
  localparam int PW = INT_W + FRAC_W;
  localparam int AW = PW + 1;
  localparam logic [AW-1:0] MIN_FP = AW'(LIM_MIN * (2 ** FRAC_W));
  localparam logic [AW-1:0] MAX_FP = AW'(LIM_MAX * (2 ** FRAC_W));

  logic [AW-1:0] posExt;
  logic [AW-1:0] velExt;
  logic [AW-1:0] rawSum;

  // Extra headroom bit on the add, floor at zero on the subtract: never wraps.
  always_comb begin
    posExt = {1'b0, pos};
    velExt = AW'(vel);
    if (dir) begin
      rawSum = posExt + velExt;
    end else if (posExt < velExt) begin
      rawSum = {AW{1'b0}};
    end else begin
      rawSum = posExt - velExt;
    end
    atMin = (rawSum <= MIN_FP);
    atMax = (rawSum >= MAX_FP);
    if (atMin) begin
      nextPos = MIN_FP[PW-1:0];
    end else if (atMax) begin
      nextPos = MAX_FP[PW-1:0];
    end else begin
      nextPos = rawSum[PW-1:0];
    end
  end

endmodule

// File: rtl/ball_motion_fp.sv
// ball_motion_fp: fixed-point pong ball mover with serve/score state machine,
// per-hit speed-up, goal detection and wall bounce, all gated by the frame tick.
// Optional feature macro: RANDOM_SERVE_EN (LFSR picks the vertical serve
// direction; otherwise the serve direction alternates, starting upward).
module ball_motion_fp
  import ball_pkg::*;
#(
  parameter int X_WIDTH     = X_WIDTH_DEF,
  parameter int Y_WIDTH     = Y_WIDTH_DEF,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int VEL_WIDTH   = VEL_WIDTH_DEF,
  parameter int X_START     = 115,
  parameter int Y_START     = 160,
  parameter int X_MIN       = 20,
  parameter int X_MAX       = 220,
  parameter int Y_MIN       = 5,
  parameter int Y_MAX       = 315,
  parameter int HIT_WINDOW  = 10,
  parameter int VEL_INIT    = 5,
  parameter int VEL_INC     = 1,
  parameter int VEL_MAX     = 32,
  parameter int SERVE_DELAY = 60
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 serve_req,
  input  logic                 paddle_hit,
  input  logic [1:0]           hit_zone,
  output logic [X_WIDTH-1:0]   ball_x,
  output logic [Y_WIDTH-1:0]   ball_y,
  output logic                 x_dir,
  output logic                 in_play,
  output logic                 score_left,
  output logic                 score_right,
  output logic [VEL_WIDTH-1:0] speed
);
  localparam int XP_W  = X_WIDTH + FRAC_BITS;
  localparam int YP_W  = Y_WIDTH + FRAC_BITS;
  localparam int VW1   = VEL_WIDTH + 1;
  localparam int CNT_W = $clog2(SERVE_DELAY + 1);

  localparam logic [XP_W-1:0]      X_START_FP = XP_W'(X_START * (2 ** FRAC_BITS));
  localparam logic [YP_W-1:0]      Y_START_FP = YP_W'(Y_START * (2 ** FRAC_BITS));
  localparam logic [X_WIDTH-1:0]   HIT_LO     = X_WIDTH'(X_MIN + HIT_WINDOW);
  localparam logic [X_WIDTH-1:0]   HIT_HI     = X_WIDTH'(X_MAX - HIT_WINDOW);
  localparam logic [CNT_W-1:0]     CNT_LOAD   = CNT_W'(SERVE_DELAY - 1);
  localparam logic [VEL_WIDTH-1:0] VEL_INIT_V = VEL_WIDTH'(VEL_INIT);
  localparam logic [VEL_WIDTH-1:0] VEL_MAX_V  = VEL_WIDTH'(VEL_MAX);
  localparam logic [VW1-1:0]       VEL_MAX_W  = VW1'(VEL_MAX);

  ballState_t stateR, stateNext;
  logic [XP_W-1:0]      posXR, posXNext, xStepPos;
  logic [YP_W-1:0]      posYR, posYNext, yStepPos;
  logic                 xDirR, xDirNext, yDirR, yDirNext;
  logic [VEL_WIDTH-1:0] speedR, speedNext, speedSat;
  logic [VW1-1:0]       speedSum;
  logic [CNT_W-1:0]     cntR, cntNext;
  logic                 scoreLeftR, scoreLeftNext, scoreRightR, scoreRightNext;
  logic                 xAtMin, xAtMax, yAtMin, yAtMax;
  logic                 hitOk, enterPlay, serveYDir;
  logic [X_WIDTH-1:0]   ballXInt;

  assign ballXInt = posXR[XP_W-1:FRAC_BITS];
  assign speedSum = {1'b0, speedR} + VW1'(VEL_INC);
  assign speedSat = (speedSum > VEL_MAX_W) ? VEL_MAX_V : speedSum[VEL_WIDTH-1:0];

  ball_axis_step #(.INT_W(X_WIDTH), .FRAC_W(FRAC_BITS), .VEL_W(VEL_WIDTH),
                   .LIM_MIN(X_MIN), .LIM_MAX(X_MAX)) xStep (
    .pos(posXR), .vel(speedR), .dir(xDirR),
    .nextPos(xStepPos), .atMin(xAtMin), .atMax(xAtMax)
  );

  ball_axis_step #(.INT_W(Y_WIDTH), .FRAC_W(FRAC_BITS), .VEL_W(VEL_WIDTH),
                   .LIM_MIN(Y_MIN), .LIM_MAX(Y_MAX)) yStep (
    .pos(posYR), .vel(speedR), .dir(yDirR),
    .nextPos(yStepPos), .atMin(yAtMin), .atMax(yAtMax)
  );

`ifdef RANDOM_SERVE_EN
  logic [15:0] lfsrR;
  // Free-running LFSR; its low bit chooses the vertical direction of each serve.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsrR <= LFSR_SEED;
    else        lfsrR <= lfsrStep(lfsrR);
  end
  assign serveYDir = lfsrR[0];
`else
  logic altDirR;
  // Alternate the vertical serve direction each time play starts, first one up.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         altDirR <= 1'b0;
    else if (enterPlay) altDirR <= ~altDirR;
    else                altDirR <= altDirR;
  end
  assign serveYDir = altDirR;
`endif

  // Play-state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stateR <= IDLE;
    else        stateR <= stateNext;
  end

  // Next-state and datapath decisions; hit beats goal, wall beats hit_zone.
  always_comb begin
    stateNext      = stateR;
    posXNext       = posXR;
    posYNext       = posYR;
    xDirNext       = xDirR;
    yDirNext       = yDirR;
    speedNext      = speedR;
    cntNext        = cntR;
    scoreLeftNext  = 1'b0;
    scoreRightNext = 1'b0;
    enterPlay      = 1'b0;
    hitOk = paddle_hit & ((~xDirR & (ballXInt <= HIT_LO)) | (xDirR & (ballXInt >= HIT_HI)));
    case (stateR)
      IDLE: begin
        if (serve_req) begin
          stateNext = SERVE_WAIT;
          cntNext   = CNT_LOAD;
        end else begin
          stateNext = IDLE;
        end
      end
      SERVE_WAIT: begin
        if (tick && (cntR == {CNT_W{1'b0}})) begin
          stateNext = PLAY;
          yDirNext  = serveYDir;
          enterPlay = 1'b1;
        end else if (tick) begin
          cntNext = cntR - CNT_W'(1);
        end else begin
          cntNext = cntR;
        end
      end
      PLAY: begin
        if (tick) begin
          posXNext = xStepPos;
          posYNext = yStepPos;
          if (hitOk) begin
            xDirNext  = ~xDirR;
            speedNext = speedSat;
          end else if (~xDirR & xAtMin) begin
            scoreRightNext = 1'b1;
            stateNext      = SCORED;
          end else if (xDirR & xAtMax) begin
            scoreLeftNext = 1'b1;
            stateNext     = SCORED;
          end else begin
            stateNext = PLAY;
          end
          if (yDirR & yAtMax) begin
            yDirNext = 1'b0;
          end else if (~yDirR & yAtMin) begin
            yDirNext = 1'b1;
          end else if (hitOk & (|hit_zone)) begin
            yDirNext = ~hit_zone[1];
          end else begin
            yDirNext = yDirR;
          end
        end else begin
          stateNext = PLAY;
        end
      end
      SCORED: begin
        posXNext  = X_START_FP;
        posYNext  = Y_START_FP;
        speedNext = VEL_INIT_V;
        xDirNext  = ~scoreRightR;
        cntNext   = CNT_LOAD;
        stateNext = SERVE_WAIT;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Position, direction, speed, serve counter and score pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      posXR       <= X_START_FP;
      posYR       <= Y_START_FP;
      xDirR       <= 1'b1;
      yDirR       <= 1'b0;
      speedR      <= VEL_INIT_V;
      cntR        <= {CNT_W{1'b0}};
      scoreLeftR  <= 1'b0;
      scoreRightR <= 1'b0;
    end else begin
      posXR       <= posXNext;
      posYR       <= posYNext;
      xDirR       <= xDirNext;
      yDirR       <= yDirNext;
      speedR      <= speedNext;
      cntR        <= cntNext;
      scoreLeftR  <= scoreLeftNext;
      scoreRightR <= scoreRightNext;
    end
  end

  assign ball_x      = posXR[XP_W-1:FRAC_BITS];
  assign ball_y      = posYR[YP_W-1:FRAC_BITS];
  assign x_dir       = xDirR;
  assign in_play     = (stateR == PLAY);
  assign score_left  = scoreLeftR;
  assign score_right = scoreRightR;
  assign speed       = speedR;

endmodule

// File: tb/tb_ball_motion_fp.sv
// tb_ball_motion_fp: randomized scoreboard bench for ball_motion_fp with a
// pixel-level reference model (positions kept as integers in 1/16 px).
module tb_ball_motion_fp;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       serve_req = 1'b0;
  logic       paddle_hit = 1'b0;
  logic [1:0] hit_zone = 2'b00;
  logic [7:0] ball_x;
  logic [8:0] ball_y;
  logic       x_dir, in_play, score_left, score_right;
  logic [5:0] speed;

  ball_motion_fp dut (
    .clock(clock), .reset(reset), .tick(tick), .serve_req(serve_req),
    .paddle_hit(paddle_hit), .hit_zone(hit_zone), .ball_x(ball_x),
    .ball_y(ball_y), .x_dir(x_dir), .in_play(in_play),
    .score_left(score_left), .score_right(score_right), .speed(speed)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] bx; logic [8:0] by; logic xd; logic ip;
    logic sl; logic sr; logic [5:0] sp;
  } obs_t;
  typedef struct { int kind; int val; } dchk_t;

  obs_t  expQ[$];
  dchk_t dirQ[$];
  int    total = 0;
  int    bad = 0;

  // Reference model: 0 idle, 1 waiting for serve, 2 playing, 3 just scored.
  int mSt, mPx, mPy, mXd, mYd, mSpd, mCnt, mSl, mSr, mAlt;

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void modelReset();
    mSt = 0; mPx = 115 * 16; mPy = 160 * 16; mXd = 1; mYd = 0;
    mSpd = 5; mCnt = 0; mSl = 0; mSr = 0; mAlt = 0;
  endfunction

  function automatic void modelStep(input bit srv, input bit tk, input bit hit, input bit [1:0] zone);
    int nx, ny, nyd, prevSr;
    bit honoured;
    prevSr = mSr;
    mSl = 0; mSr = 0;
    case (mSt)
      0: if (srv) begin mSt = 1; mCnt = 59; end
      1: if (tk) begin
           if (mCnt == 0) begin mSt = 2; mYd = mAlt; mAlt = 1 - mAlt; end
           else mCnt = mCnt - 1;
         end
      2: if (tk) begin
           honoured = hit && ((mXd == 0 && mPx / 16 <= 30) || (mXd == 1 && mPx / 16 >= 210));
           nx = (mXd == 1) ? mPx + mSpd : mPx - mSpd;
           ny = (mYd == 1) ? mPy + mSpd : mPy - mSpd;
           nyd = mYd;
           if (honoured) begin
             if (zone[1]) nyd = 0;
             else if (zone[0]) nyd = 1;
           end
           if (mYd == 1 && ny >= 315 * 16) nyd = 0;
           else if (mYd == 0 && ny <= 5 * 16) nyd = 1;
           if (honoured) begin
             mXd = 1 - mXd;
             mSpd = (mSpd + 1 > 32) ? 32 : mSpd + 1;
           end else if (mXd == 0 && nx <= 20 * 16) begin
             mSr = 1; mSt = 3;
           end else if (mXd == 1 && nx >= 220 * 16) begin
             mSl = 1; mSt = 3;
           end
           mPx = clampi(nx, 20 * 16, 220 * 16);
           mPy = clampi(ny, 5 * 16, 315 * 16);
           mYd = nyd;
         end
      default: begin
        mPx = 115 * 16; mPy = 160 * 16; mSpd = 5;
        mXd = (prevSr == 1) ? 0 : 1;
        mSt = 1; mCnt = 59;
      end
    endcase
  endfunction

  // One clock of stimulus: drive at the falling edge, push the model's view of
  // the outputs after the next rising edge, plus an optional named field check.
  task automatic cycle(input bit rstHold, input bit rstPulse, input bit srv, input bit tk,
                       input bit hit, input bit [1:0] zone, input int dKind, input int dVal);
    obs_t e;
    dchk_t d;
    @(negedge clock);
    serve_req = srv; tick = tk; paddle_hit = hit; hit_zone = zone;
    if (rstHold) begin
      reset = 1'b0;
      modelReset();
    end else begin
      reset = 1'b1;
      if (rstPulse) begin
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        modelReset();
      end
      modelStep(srv, tk, hit, zone);
    end
    e.bx = 8'(mPx / 16); e.by = 9'(mPy / 16); e.xd = 1'(mXd);
    e.ip = (mSt == 2); e.sl = 1'(mSl); e.sr = 1'(mSr); e.sp = 6'(mSpd);
    expQ.push_back(e);
    if (dKind >= 0) begin
      d.kind = dKind; d.val = dVal;
      dirQ.push_back(d);
    end
  endtask

  // Monitor: after each rising edge compare outputs with queued expectations.
  initial begin
    obs_t e, a;
    dchk_t d;
    int av;
    string nm;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = {ball_x, ball_y, x_dir, in_play, score_left, score_right, speed};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL scoreboard t=%0t actual x=%0d y=%0d xd=%0d ip=%0d sl=%0d sr=%0d sp=%0d required x=%0d y=%0d xd=%0d ip=%0d sl=%0d sr=%0d sp=%0d",
                   $time, a.bx, a.by, a.xd, a.ip, a.sl, a.sr, a.sp,
                   e.bx, e.by, e.xd, e.ip, e.sl, e.sr, e.sp);
        end
        while (dirQ.size() > 0) begin
          d = dirQ.pop_front();
          case (d.kind)
            0:       begin av = int'(in_play); nm = "in_play"; end
            1:       begin av = int'(ball_x);  nm = "ball_x";  end
            2:       begin av = int'(ball_y);  nm = "ball_y";  end
            default: begin av = int'(speed);   nm = "speed";   end
          endcase
          total++;
          if (av != d.val) begin
            bad++;
            $display("FAIL directed_%s t=%0t actual=%0d required=%0d", nm, $time, av, d.val);
          end
        end
      end
    end
  end

  // Stimulus: directed serve, long randomized play, then a reset mid-play.
  initial begin
    bit tk, hit, srv, rh;
    bit [1:0] zone;
    int blk;
    modelReset();
    repeat (4) cycle(1, 0, 0, 0, 0, 2'b00, -1, 0);
    repeat (3) cycle(0, 0, 0, 1, 1, 2'b10, 1, 115);
    cycle(0, 0, 1, 0, 0, 2'b00, 0, 0);
    for (int i = 1; i <= 60; i++) cycle(0, 0, 0, 1, 0, 2'b00, (i >= 59) ? 0 : -1, (i == 60) ? 1 : 0);
    for (int i = 1; i <= 16; i++) cycle(0, 0, 0, 1, 0, 2'b00, (i == 16) ? 1 : -1, 120);
    cycle(0, 0, 0, 0, 1, 2'b01, 2, 155);
    cycle(0, 0, 0, 0, 0, 2'b00, 3, 5);

    for (int i = 0; i < 6000; i++) begin
      blk  = (i / 800) % 3;
      tk   = ($urandom_range(0, 3) != 0);
      srv  = ($urandom_range(0, 15) == 0);
      rh   = ($urandom_range(0, 2999) == 0);
      zone = 2'($urandom_range(0, 3));
      if (blk == 0)      hit = 1'b0;
      else if (blk == 1) hit = ($urandom_range(0, 31) == 0);
      else               hit = ($urandom_range(0, 3) == 0);
      cycle(rh, 0, srv, tk, hit, zone, -1, 0);
    end

    cycle(1, 0, 0, 0, 0, 2'b00, -1, 0);
    cycle(0, 0, 1, 0, 0, 2'b00, -1, 0);
    for (int i = 1; i <= 65; i++) cycle(0, 0, 0, 1, 0, 2'b00, (i == 65) ? 0 : -1, 1);
    cycle(0, 0, 0, 0, 1, 2'b11, 1, 116);
    cycle(0, 1, 0, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 0, 1, 0, 2'b00, 1, 115);
    cycle(0, 0, 0, 1, 0, 2'b00, 3, 5);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
